// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory-port stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] FAULT_MISALIGN = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // Access size lives in f3[1:0]; the sign bit f3[2] does not affect lanes.
  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Data-memory request/response bus between the LSU port (master) and memory (slave).
interface lsu_mem_port_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/lsu_align_check.sv
// Combinational op decode: byte-enable mask, lane-replicated store data, alignment
// and funct3 legality for one load/store.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        is_store,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    be = be_mask(f3[1:0], addr_lo);

    wdata_rep = wdata;
    case (f3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: ;
    endcase

    illegal = 1'b1;
    if (is_store) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: illegal = 1'b0;
        default: ;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
        default: ;
      endcase
    end

    misaligned = 1'b0;
    case (f3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store memory-port stage: single outstanding data-memory access with fault pulses.
// Optional request/response timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_f3,
  lsu_mem_port_if.master    mem,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [3:0]        rd_be_mask,
  output logic [2:0]        rd_f3,
  output logic              st_done,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);

  lsu_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rd_data_q;
  logic [3:0]        rd_be_q;
  logic [2:0]        rd_f3_q;
  logic              fault_q;
  logic [1:0]        fault_code_q;

  logic [3:0]  chk_be;
  logic [31:0] chk_wdata;
  logic        chk_misaligned;
  logic        chk_illegal;

  logic accept, op_bad, mem_hs, rsp_take, tmo_hit, tmo_fire;

  lsu_align_check u_align_check (
    .f3         (req_f3),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .is_store   (req_is_store),
    .be         (chk_be),
    .wdata_rep  (chk_wdata),
    .misaligned (chk_misaligned),
    .illegal    (chk_illegal)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q;

  assign tmo_hit = ((state_q == REQ) || (state_q == WAIT)) && (tmo_cnt_q == TmoLast);

  // Restarts on every entry into REQ or WAIT, so each phase gets the full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if ((state_d != state_q) && ((state_d == REQ) || (state_d == WAIT))) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit            = 1'b0;
`endif

  always_comb begin
    accept   = (state_q == IDLE) && req_valid;
    op_bad   = chk_illegal || chk_misaligned;
    mem_hs   = (state_q == REQ) && mem.mem_req_ready;
    rsp_take = (state_q == WAIT) && mem.mem_rsp_valid;
    tmo_fire = tmo_hit && (((state_q == REQ) && !mem.mem_req_ready) ||
                           ((state_q == WAIT) && !mem.mem_rsp_valid));

    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !op_bad) state_d = REQ;
      REQ: begin
        if (mem_hs)        state_d = we_q ? IDLE : WAIT;
        else if (tmo_fire) state_d = IDLE;
      end
      WAIT: begin
        if (rsp_take)      state_d = RESP;
        else if (tmo_fire) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      rd_data_q    <= '0;
      rd_be_q      <= '0;
      rd_f3_q      <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_MISALIGN;
    end else begin
      state_q <= state_d;
      fault_q <= 1'b0;
      if (accept) begin
        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        we_q    <= req_is_store;
        be_q    <= chk_be;
        wdata_q <= chk_wdata;
        f3_q    <= req_f3;
        if (op_bad) begin
          fault_q      <= 1'b1;
          fault_code_q <= chk_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
        end
      end
      if (rsp_take) begin
        rd_data_q <= mem.mem_rsp_rdata;
        rd_be_q   <= be_q;
        rd_f3_q   <= f3_q;
      end
      if (tmo_fire) begin
        fault_q      <= 1'b1;
        fault_code_q <= FAULT_TIMEOUT;
      end
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_addr      = addr_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_be        = be_q;
  assign mem.mem_wdata     = wdata_q;
  assign st_done           = mem_hs && we_q;
  assign rd_valid          = (state_q == RESP);
  assign rd_data           = rd_data_q;
  assign rd_be_mask        = rd_be_q;
  assign rd_f3             = rd_f3_q;
  assign fault             = fault_q;
  assign fault_code        = fault_code_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: expected loads, stores and faults are queued at
// stimulus time and retired by a negedge monitor when the DUT pulses.
module tb_lsu_mem_port;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic [2:0]  f3;
  } rd_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_f3;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_be_mask;
  logic [2:0]  rd_f3;
  logic        st_done;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;

  int checks   = 0;
  int failures = 0;

  rd_exp_t    exp_rd[$];
  st_exp_t    exp_st[$];
  logic [1:0] exp_flt[$];

  lsu_mem_port_if #(.ADDR_W(32)) mem_if ();

  lsu_mem_port #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_f3       (req_f3),
    .mem          (mem_if),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_be_mask   (rd_be_mask),
    .rd_f3        (rd_f3),
    .st_done      (st_done),
    .busy         (busy),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Retires scoreboard entries whenever the DUT emits a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", rd_valid, 1'b0);
        end else begin
          rd_exp_t e;
          e = exp_rd.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_be_mask", rd_be_mask, e.be);
          check("rd_f3", rd_f3, e.f3);
        end
      end
      if (st_done) begin
        if (exp_st.size() == 0) begin
          check("st_unexpected", st_done, 1'b0);
        end else begin
          st_exp_t s;
          s = exp_st.pop_front();
          check("st_addr", mem_if.mem_addr, s.addr);
          check("st_be", mem_if.mem_be, s.be);
          check("st_wdata", mem_if.mem_wdata, s.wdata);
          check("st_we", mem_if.mem_we, 1'b1);
        end
      end
      if (fault) begin
        if (exp_flt.size() == 0) check("fault_unexpected", fault, 1'b0);
        else check("fault_code", fault_code, exp_flt.pop_front());
      end
    end
  end

  // Presents one op; returns just after the accepting edge (first cycle after accept).
  task automatic drive_op(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_addr     = addr;
    req_wdata    = wd;
    req_f3       = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic step_post;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        st;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [1:0]  code;
  } flt_vec_t;

  initial begin
    flt_vec_t fv[5];
    fv[0] = '{st: 1'b0, addr: 32'h10,   f3: 3'd3, code: 2'b01};
    fv[1] = '{st: 1'b0, addr: 32'h1,    f3: 3'd2, code: 2'b00};
    fv[2] = '{st: 1'b1, addr: 32'h20,   f3: 3'd4, code: 2'b01};
    fv[3] = '{st: 1'b1, addr: 32'h2001, f3: 3'd1, code: 2'b00};
    fv[4] = '{st: 1'b0, addr: 32'h6,    f3: 3'd6, code: 2'b01};

    rst                  = 1'b1;
    req_valid            = 1'b0;
    req_is_store         = 1'b0;
    req_addr             = '0;
    req_wdata            = '0;
    req_f3               = '0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;

    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req_valid", mem_if.mem_req_valid, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_st_done", st_done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_addr", mem_if.mem_addr, 32'h0);
    check("rst_mem_be", mem_if.mem_be, 4'h0);
    check("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_fault_code", fault_code, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load byte at 0x1003, memory ready immediately, data one cycle later.
    mem_if.mem_req_ready = 1'b1;
    exp_rd.push_back('{data: 32'hAABBCCDD, be: 4'b1000, f3: 3'd0});
    drive_op(1'b0, 32'h1003, 32'h0, 3'd0);
    @(negedge clk);
    check("lb_req_valid", mem_if.mem_req_valid, 1'b1);
    check("lb_addr", mem_if.mem_addr, 32'h1000);
    check("lb_be", mem_if.mem_be, 4'b1000);
    check("lb_we", mem_if.mem_we, 1'b0);
    check("lb_busy", busy, 1'b1);
    check("lb_req_ready", req_ready, 1'b0);
    step_post();
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 32'hAABBCCDD;
    step_post();
    mem_if.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("lb_rd_valid_n3", rd_valid, 1'b1);
    @(negedge clk);
    check("lb_rd_valid_drop", rd_valid, 1'b0);
    check("lb_idle", req_ready, 1'b1);
    check("lb_retired", exp_rd.size(), 0);

    // Store half at 0x2002.
    exp_st.push_back('{addr: 32'h2000, be: 4'b1100, wdata: 32'hBEEFBEEF});
    drive_op(1'b1, 32'h2002, 32'h0000BEEF, 3'd1);
    @(negedge clk);
    check("sh_st_done_n1", st_done, 1'b1);
    @(negedge clk);
    check("sh_st_done_drop", st_done, 1'b0);
    check("sh_idle", busy, 1'b0);

    // Illegal f3 and misaligned ops: fault pulse, no memory request.
    foreach (fv[i]) begin
      exp_flt.push_back(fv[i].code);
      drive_op(fv[i].st, fv[i].addr, 32'h0, fv[i].f3);
      @(negedge clk);
      check("flt_pulse", fault, 1'b1);
      check("flt_code", fault_code, fv[i].code);
      check("flt_no_req", mem_if.mem_req_valid, 1'b0);
      check("flt_busy", busy, 1'b0);
      @(negedge clk);
      check("flt_pulse_drop", fault, 1'b0);
      check("flt_no_req2", mem_if.mem_req_valid, 1'b0);
      check("flt_code_hold", fault_code, fv[i].code);
    end

    // Backpressure: ready low for 5 cycles, request must hold.
    mem_if.mem_req_ready = 1'b0;
    exp_st.push_back('{addr: 32'h4000, be: 4'b1111, wdata: 32'h12345678});
    drive_op(1'b1, 32'h4000, 32'h12345678, 3'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", mem_if.mem_req_valid, 1'b1);
      check("bp_addr", mem_if.mem_addr, 32'h4000);
      check("bp_be", mem_if.mem_be, 4'b1111);
      check("bp_wdata", mem_if.mem_wdata, 32'h12345678);
      check("bp_busy", busy, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_st_done", st_done, (i == 5));
      if (i == 4) begin
        step_post();
        mem_if.mem_req_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("bp_done_idle", busy, 1'b0);

    // Half load with stray responses before and at the handshake.
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 32'hDEADBEEF;
    exp_rd.push_back('{data: 32'h11223344, be: 4'b1100, f3: 3'd5});
    drive_op(1'b0, 32'h3002, 32'h0, 3'd5);
    step_post();
    mem_if.mem_req_ready = 1'b1;
    step_post();
    mem_if.mem_rsp_valid = 1'b0;
    step_post();
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 32'h11223344;
    step_post();
    mem_if.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("lhu_rd_valid", rd_valid, 1'b1);
    @(negedge clk);
    check("lhu_rd_hold", rd_data, 32'h11223344);
    check("lhu_be_hold", rd_be_mask, 4'b1100);
    check("lhu_retired", exp_rd.size(), 0);

    // Reset while waiting for a load response.
    drive_op(1'b0, 32'h5000, 32'h0, 3'd2);
    step_post();
    @(negedge clk);
    check("rw_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rw_busy_rst", busy, 1'b0);
    check("rw_req_ready_rst", req_ready, 1'b1);
    check("rw_rd_valid_rst", rd_valid, 1'b0);
    check("rw_rd_data_rst", rd_data, 32'h0);
    check("rw_req_valid_rst", mem_if.mem_req_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step_post();
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 32'h00000055;
    repeat (2) @(negedge clk);
    check("rw_stray_rsp", rd_valid, 1'b0);
    step_post();
    mem_if.mem_rsp_valid = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // No response: four cycles in WAIT, then timeout fault.
    exp_flt.push_back(2'b10);
    drive_op(1'b0, 32'h6000, 32'h0, 3'd2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tmo_waiting", busy, 1'b1);
      check("tmo_no_fault", fault, 1'b0);
    end
    @(negedge clk);
    check("tmo_fault", fault, 1'b1);
    check("tmo_code", fault_code, 2'b10);
    check("tmo_idle", busy, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("end_rd_q", exp_rd.size(), 0);
    check("end_st_q", exp_st.size(), 0);
    check("end_flt_q", exp_flt.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
